// File: rtl/gpio_burst_rx.sv
`default_nettype none
// ============================================================================
// Module   : gpio_burst_rx
// Purpose  : Receive front-end between the Raspberry Pi GPIO bus and the HSM
//            core. Captures one byte per CLK_50 cycle while rp_cs is high,
//            checks each burst for exactly BURST_SIZE bytes, and stores only
//            good bursts in a commit/rollback FIFO. Stored bytes are streamed
//            out on a valid/ready interface with an end-of-burst marker.
// Ports    : CLK_50, rst (async, active-high)
//            rp_cs, rp_data            - GPIO burst input
//            m_data, m_last, m_valid,
//            m_ready                   - downstream byte stream
//            burst_done                - one-cycle pulse per committed burst
//            short_err, long_err,
//            ovf_err, clr_err          - sticky error flags and their clear
//            byte_cnt                  - bytes captured in the current burst
// Revision : 1.0 - initial release
// ============================================================================
module gpio_burst_rx #(
  parameter int DATA_W     = 8,
  parameter int BURST_SIZE = 8,
  parameter int DEPTH      = 16
) (
  input  logic                            CLK_50,
  input  logic                            rst,
  input  logic                            rp_cs,
  input  logic [DATA_W-1:0]               rp_data,
  output logic [DATA_W-1:0]               m_data,
  output logic                            m_last,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic                            burst_done,
  output logic                            short_err,
  output logic                            long_err,
  output logic                            ovf_err,
  input  logic                            clr_err,
  output logic [$clog2(BURST_SIZE+1)-1:0] byte_cnt
);

  localparam int c_ptr_w = $clog2(DEPTH) + 1;
  localparam int c_idx_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(BURST_SIZE + 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(BURST_SIZE);
  localparam logic [c_ptr_w-1:0] c_depth = c_ptr_w'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t r_state, w_state_n;

  logic                r_cs_q;
  logic [DATA_W-1:0]   r_data_q;
  logic [DATA_W:0]     r_mem [DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr, r_rd_ptr, r_commit_ptr;
  logic [c_cnt_w-1:0]  r_byte_cnt, w_cnt_n, w_cnt_base, w_cnt_inc;
  logic                r_bad, w_bad_n;
  logic                r_extra, w_extra_n;
  logic                r_done;
  logic                r_short, r_long, r_ovf;
  logic                w_write, w_commit, w_rollback;
  logic                w_set_short, w_set_long, w_set_ovf;
  logic                w_free, w_read, w_last_bit;
  logic [c_ptr_w-1:0]  w_used;
  logic [DATA_W:0]     w_head;

  // Uncommitted entries are counted as used, so a capture can never
  // overwrite data the downstream stage has not read yet.
  assign w_used  = r_wr_ptr - r_rd_ptr;
  assign w_free  = (w_used != c_depth);
  assign m_valid = (r_commit_ptr != r_rd_ptr);
  assign w_read  = m_valid & m_ready;
  assign w_head  = r_mem[r_rd_ptr[c_idx_w-1:0]];
  assign m_data  = w_head[DATA_W-1:0];
  assign m_last  = w_head[DATA_W];

  assign burst_done = r_done;
  assign short_err  = r_short;
  assign long_err   = r_long;
  assign ovf_err    = r_ovf;
  assign byte_cnt   = r_byte_cnt;

  // A new burst starts counting from zero with a clean "bad" flag; IDLE
  // handles the first byte in the same cycle it leaves for CAPTURE.
  assign w_cnt_base = (r_state == S_IDLE) ? '0 : r_byte_cnt;
  assign w_cnt_inc  = w_cnt_base + c_cnt_w'(1);
  assign w_last_bit = (w_cnt_inc == c_last);

  always_ff @(posedge CLK_50 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_cnt_n     = r_byte_cnt;
    w_bad_n     = r_bad;
    w_extra_n   = r_extra;
    w_write     = 1'b0;
    w_commit    = 1'b0;
    w_rollback  = 1'b0;
    w_set_short = 1'b0;
    w_set_long  = 1'b0;
    w_set_ovf   = 1'b0;
    case (r_state)
      S_IDLE, S_CAPTURE: begin
        if (r_cs_q) begin
          w_bad_n = (r_state == S_IDLE) ? 1'b0 : r_bad;
          if (w_free) begin
            w_write = 1'b1;
          end else begin
            w_set_ovf = 1'b1;
            w_bad_n   = 1'b1;
          end
          // Bytes are counted even when dropped so an overflowed burst
          // still terminates at its nominal length.
          w_cnt_n   = w_cnt_inc;
          w_state_n = S_CAPTURE;
          if (w_last_bit) begin
            w_state_n = S_HOLD;
            w_extra_n = 1'b0;
            if (w_bad_n) begin
              w_rollback = 1'b1;
            end else begin
              w_commit = 1'b1;
            end
          end
        end else if (r_state == S_CAPTURE) begin
          w_set_short = 1'b1;
          w_rollback  = 1'b1;
          w_cnt_n     = '0;
          w_state_n   = S_IDLE;
        end
      end
      S_HOLD: begin
        if (r_cs_q) begin
          if (!r_extra) begin
            w_set_long = 1'b1;
            w_extra_n  = 1'b1;
          end
        end else begin
          w_cnt_n   = '0;
          w_extra_n = 1'b0;
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK_50 or posedge rst) begin
    if (rst) begin
      r_cs_q       <= 1'b0;
      r_data_q     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_commit_ptr <= '0;
      r_byte_cnt   <= '0;
      r_bad        <= 1'b0;
      r_extra      <= 1'b0;
      r_done       <= 1'b0;
      r_short      <= 1'b0;
      r_long       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_cs_q     <= rp_cs;
      r_data_q   <= rp_data;
      r_byte_cnt <= w_cnt_n;
      r_bad      <= w_bad_n;
      r_extra    <= w_extra_n;
      r_done     <= w_commit;
      if (w_rollback) begin
        r_wr_ptr <= r_commit_ptr;
      end else if (w_write) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      // A good burst's final byte is written this cycle, so commit
      // includes it.
      if (w_commit) begin
        r_commit_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_read) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      // A new error outranks a simultaneous clear.
      if (w_set_short) r_short <= 1'b1;
      else if (clr_err) r_short <= 1'b0;
      if (w_set_long) r_long <= 1'b1;
      else if (clr_err) r_long <= 1'b0;
      if (w_set_ovf) r_ovf <= 1'b1;
      else if (clr_err) r_ovf <= 1'b0;
    end
  end

  // Storage is cleared on reset so the head outputs read zero.
  always_ff @(posedge CLK_50 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_write) begin
      r_mem[r_wr_ptr[c_idx_w-1:0]] <= {w_last_bit, r_data_q};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpio_burst_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_burst_rx
// Purpose  : Directed self-checking bench for gpio_burst_rx.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_burst_rx;

  logic       clk;
  logic       rst;
  logic       rp_cs;
  logic [7:0] rp_data;
  logic [7:0] m_data;
  logic       m_last;
  logic       m_valid;
  logic       m_ready;
  logic       burst_done;
  logic       short_err;
  logic       long_err;
  logic       ovf_err;
  logic       clr_err;
  logic [3:0] byte_cnt;

  int checks   = 0;
  int failures = 0;

  logic [8:0] rxq  [$];
  logic [8:0] expq [$];

  logic       hold_pending = 1'b0;
  logic [8:0] held;

  gpio_burst_rx #(.DATA_W(8), .BURST_SIZE(8), .DEPTH(16)) dut (
    .CLK_50    (clk),
    .rst       (rst),
    .rp_cs     (rp_cs),
    .rp_data   (rp_data),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .burst_done(burst_done),
    .short_err (short_err),
    .long_err  (long_err),
    .ovf_err   (ovf_err),
    .clr_err   (clr_err),
    .byte_cnt  (byte_cnt)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs only change 1 ns after a rising edge, so at the falling edge a
  // valid&ready pair is exactly a transfer happening at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", {m_last, m_data}, held);
      end
      if (m_valid && m_ready) rxq.push_back({m_last, m_data});
      hold_pending = m_valid && !m_ready;
      held         = {m_last, m_data};
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives n bytes, one per cycle, then drops rp_cs (without advancing).
  task automatic send_burst(input logic [7:0] first, input logic [7:0] inc,
                            input int n, input bit toggle);
    logic [7:0] d;
    d = first;
    for (int i = 0; i < n; i++) begin
      rp_cs   = 1'b1;
      rp_data = d;
      if (toggle) m_ready = ~m_ready;
      step(1);
      d = d + inc;
    end
    rp_cs = 1'b0;
  endtask

  task automatic add_exp(input logic [7:0] first, input logic [7:0] inc, input int n);
    logic [7:0] d;
    d = first;
    for (int i = 0; i < n; i++) begin
      expq.push_back({(i == n - 1), d});
      d = d + inc;
    end
  endtask

  task automatic check_stream(input string tag);
    chk({tag, "_len"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < rxq.size()) chk({tag, "_byte"}, rxq[i], expq[i]);
    end
    rxq.delete();
    expq.delete();
  endtask

  initial begin
    rst     = 1'b1;
    rp_cs   = 1'b0;
    rp_data = 8'h00;
    m_ready = 1'b1;
    clr_err = 1'b0;
    step(3);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", {m_last, m_data}, 0);
    chk("rst_done", burst_done, 0);
    chk("rst_errs", {short_err, long_err, ovf_err}, 0);
    chk("rst_cnt", byte_cnt, 0);
    rst = 1'b0;
    step(2);

    // Good burst with latency checks around the final byte.
    send_burst(8'h88, 8'h11, 8, 1'b0);
    chk("t1_cnt7", byte_cnt, 7);
    chk("t1_valid_early", m_valid, 0);
    step(1);
    chk("t1_valid", m_valid, 1);
    chk("t1_done", burst_done, 1);
    chk("t1_head", {m_last, m_data}, 9'h088);
    chk("t1_cnt8", byte_cnt, 8);
    step(1);
    chk("t1_done_pulse", burst_done, 0);
    step(10);
    add_exp(8'h88, 8'h11, 8);
    check_stream("t1");
    chk("t1_errs", {short_err, long_err, ovf_err}, 0);
    chk("t1_cnt_idle", byte_cnt, 0);

    // Short burst is rolled back.
    send_burst(8'h11, 8'h11, 5, 1'b0);
    step(2);
    chk("t2_short", short_err, 1);
    chk("t2_cnt", byte_cnt, 0);
    chk("t2_valid", m_valid, 0);
    step(5);
    check_stream("t2");
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("t2_clr", short_err, 0);

    // Long burst: first 8 bytes delivered, extras dropped.
    send_burst(8'h01, 8'h01, 10, 1'b0);
    step(12);
    chk("t3_long", long_err, 1);
    chk("t3_short", short_err, 0);
    chk("t3_cnt", byte_cnt, 0);
    add_exp(8'h01, 8'h01, 8);
    check_stream("t3");
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;
    chk("t3_clr", long_err, 0);

    // Fill the FIFO with back-to-back bursts, then overflow.
    m_ready = 1'b0;
    send_burst(8'hA0, 8'h01, 8, 1'b0);
    step(1);
    send_burst(8'hB0, 8'h01, 8, 1'b0);
    step(1);
    send_burst(8'hC0, 8'h01, 8, 1'b0);
    step(4);
    chk("t4_ovf", ovf_err, 1);
    chk("t4_valid", m_valid, 1);
    chk("t4_head", {m_last, m_data}, 9'h0A0);
    m_ready = 1'b1;
    step(24);
    chk("t4_empty", m_valid, 0);
    add_exp(8'hA0, 8'h01, 8);
    add_exp(8'hB0, 8'h01, 8);
    check_stream("t4");
    clr_err = 1'b1;
    step(1);
    clr_err = 1'b0;

    // Reset mid-burst with an unread burst waiting.
    m_ready = 1'b0;
    send_burst(8'h10, 8'h01, 8, 1'b0);
    step(4);
    chk("t5_pending", m_valid, 1);
    for (int i = 0; i < 4; i++) begin
      rp_cs   = 1'b1;
      rp_data = 8'h20 + 8'(i);
      step(1);
    end
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", m_valid, 0);
    chk("t5_rst_cnt", byte_cnt, 0);
    chk("t5_rst_data", {m_last, m_data}, 0);
    rp_cs = 1'b0;
    step(1);
    rst = 1'b0;
    rxq.delete();
    m_ready = 1'b1;
    step(1);
    send_burst(8'h88, 8'h11, 8, 1'b0);
    step(12);
    add_exp(8'h88, 8'h11, 8);
    check_stream("t5");

    // Ready toggling while a second burst is captured behind a first.
    m_ready = 1'b0;
    send_burst(8'h40, 8'h01, 8, 1'b0);
    step(1);
    send_burst(8'h50, 8'h01, 8, 1'b1);
    for (int i = 0; i < 40; i++) begin
      m_ready = ~m_ready;
      step(1);
    end
    m_ready = 1'b1;
    step(2);
    add_exp(8'h40, 8'h01, 8);
    add_exp(8'h50, 8'h01, 8);
    check_stream("t6");
    chk("t6_errs", {short_err, long_err, ovf_err}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
